t_stream_monitor: RTL and testbench
===================================

Name: t_stream_monitor

Overview:
- Downstream consumer of the single-bit selector output T from the flip-flop/mux stage.
- Samples T on qualified clock edges and packs it into WIDTH-bit words, with a per-word ones count.
- Detects a programmable serial pattern in the bit stream; overlapping occurrences count.
- Gives the board/testbench one registered observation point for the upstream stage's sequential behaviour.

Parameters:
- WIDTH, 8, bits per captured word (2..16).
- PAT_LEN, 4, length of the detected pattern (2..WIDTH).
- PATTERN, 4'b1011, pattern value (PAT_LEN bits); the MSB is the earliest bit received.

Ports:
- clk  input  1  system clock, rising edge.
- s_reset  input  1  asynchronous, active-high reset.
- T  input  1  serial bit from the upstream stage.
- sample_en  input  1  high: T is accepted at this rising edge.
- clear  input  1  synchronous clear of capture/detect state; counters are cleared too.
- word_q  output  WIDTH  last completed word; the first bit received sits in the MSB.
- word_valid  output  1  one-cycle pulse when word_q updates.
- ones_count  output  $clog2(WIDTH+1)  number of 1s in word_q.
- match  output  1  one-cycle pulse on pattern detect.
- match_count  output  8  saturating count of matches.
- state  output  2  FSM state: 0 IDLE, 1 FILL, 2 ARMED.
- word_parity  output  1  XOR of word_q bits (see Optional Feature).

Behaviour:
- Reset (async, s_reset=1): every output goes to 0 and state=IDLE. Internal shift register, window, bit_cnt and fill_cnt are all 0. This takes effect immediately, without waiting for a clock edge. Release is sampled on the next clk edge.
- Accepted bit: a rising edge with sample_en=1 and clear=0. On any other edge, capture/detect state holds and match/word_valid are 0.
- Shift: shift_r <= {shift_r[WIDTH-2:0], T}; window <= {window[PAT_LEN-2:0], T}.
- bit_cnt counts accepted bits from 0 to WIDTH-1. When a bit is accepted with bit_cnt==WIDTH-1:
  - word_q <= {shift_r[WIDTH-2:0], T};
  - ones_count <= popcount of that same value;
  - word_valid is 1 for the following cycle;
  - bit_cnt wraps to 0.
- Back-to-back words need no gap cycle.
- FSM (updates on accepted bits only, except for clear):
  - IDLE -> FILL on the first accepted bit.
  - FILL -> ARMED when the accepted bit brings fill_cnt to PAT_LEN.
  - ARMED holds until clear or reset.
  - If PAT_LEN bits arrive, ARMED is reached on the PAT_LEN-th accepted bit.
- Match:
  - Condition: an accepted bit whose updated window equals PATTERN, while the FSM is in ARMED or transitioning into ARMED on that bit.
  - Response: match=1 for exactly one cycle after that edge (registered, latency 1); match_count increments the same edge.
  - Overlap is allowed: the window is never flushed on a match.
- match_count saturates at 255: a further match still pulses match, but the count stays at 255.
- clear=1 at an edge (takes priority over sample_en; the T bit on that edge is discarded):
  - clears shift_r, window, bit_cnt, fill_cnt and match_count;
  - sets state=IDLE and match=0, word_valid=0;
  - word_q and ones_count keep the last completed word.
- Partial words: a word in progress when clear or reset occurs is discarded; word_valid is not asserted for it.
- Reset mid-word or mid-pattern: all progress is lost; counting restarts from bit 0 after release.
- sample_en gaps of any length are transparent: capture resumes with the next accepted bit.

Optional Feature:
- Macro: T_STREAM_PARITY_EN.
- Defined: word_parity is registered together with word_q and equals the XOR of the new word. It is 0 after reset, and clear does not change it.
- Undefined: word_parity is tied to constant 0 and no parity logic is synthesized. The port is still present in both builds.

Test Plan:
- Async reset: assert s_reset between clock edges after 5 accepted bits -> all outputs 0 before the next edge, state=0. After release, feeding 8 bits produces word_valid exactly on the 8th accepted bit, not the 3rd.
- Pattern: with sample_en=1 feed T=1,0,1,1 -> state goes 1,1,1,2; match=1 for one cycle after the 4th bit; match_count=1.
- Overlap: feed 1,0,1,1,0,1,1 -> two match pulses, after bits 4 and 7; match_count=2.
- Word: feed 1,1,0,0,1,0,1,0 with sample_en toggling 1,0 on alternate cycles -> word_q=8'hCA, ones_count=4, one word_valid pulse. With the macro defined, word_parity=0.
- Clear priority: clear=1 and sample_en=1 with T=1 on the same edge in ARMED, match_count=3 -> state=0, match_count=0, word_q unchanged, the bit not counted; the next 4 bits 1,0,1,1 produce a match.
- Saturation: force 256 matches via a repeating 1011 stream -> match_count stays at 255, and match still pulses on every detect.

Source files
------------

// File: rtl/t_stream_monitor.sv
// Serial monitor for the upstream T bit: packs accepted bits into words and counts pattern hits.
// Optional T_STREAM_PARITY_EN registers the XOR of each completed word on word_parity.
module t_stream_monitor #(
   parameter int                 WIDTH   = 8,
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
   input  logic                         clk,
   input  logic                         s_reset,
   input  logic                         T,
   input  logic                         sample_en,
   input  logic                         clear,
   output logic [WIDTH-1:0]             word_q,
   output logic                         word_valid,
   output logic [$clog2(WIDTH+1)-1:0]   ones_count,
   output logic                         match,
   output logic [7:0]                   match_count,
   output logic [1:0]                   state,
   output logic                         word_parity
);

   localparam int CW = $clog2(WIDTH+1);
   localparam int BW = $clog2(WIDTH);
   localparam int FW = $clog2(PAT_LEN+1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_ARMED = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-2:0]   r_shift;
   logic [PAT_LEN-2:0] r_window;
   logic [BW-1:0]      r_bit_cnt;
   logic [FW-1:0]      r_fill_cnt;
   logic [FW-1:0]      w_fill_next;
   logic               w_accept;
   logic               w_match_hit;
   logic [WIDTH-1:0]   w_word_next;
   logic [PAT_LEN-1:0] w_window_next;
   logic [CW-1:0]      w_ones;

   assign w_accept      = sample_en & ~clear;
   assign w_word_next   = {r_shift, T};
   assign w_window_next = {r_window, T};
   assign w_fill_next   = (r_fill_cnt == FW'(PAT_LEN)) ? r_fill_cnt : r_fill_cnt + FW'(1);

   // A hit needs a full window: either already armed or arming on this very bit.
   assign w_match_hit   = w_accept && (w_window_next == PATTERN) && (w_next_state == S_ARMED);

   always_comb begin
      w_ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_ones = w_ones + CW'(w_word_next[i]);
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge s_reset) begin
      if (s_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM: next-state logic
   always_comb begin
      w_next_state = r_state;
      if (clear) begin
         w_next_state = S_IDLE;
      end else if (sample_en) begin
         case (r_state)
            S_IDLE:  w_next_state = S_FILL;
            S_FILL:  if (w_fill_next == FW'(PAT_LEN)) w_next_state = S_ARMED;
            S_ARMED: w_next_state = S_ARMED;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      state = r_state;
   end

   always_ff @(posedge clk or posedge s_reset) begin
      if (s_reset) begin
         r_shift     <= '0;
         r_window    <= '0;
         r_bit_cnt   <= '0;
         r_fill_cnt  <= '0;
         word_q      <= '0;
         ones_count  <= '0;
         word_valid  <= 1'b0;
         match       <= 1'b0;
         match_count <= '0;
      end else if (clear) begin
         // word_q and ones_count deliberately keep the last completed word
         r_shift     <= '0;
         r_window    <= '0;
         r_bit_cnt   <= '0;
         r_fill_cnt  <= '0;
         word_valid  <= 1'b0;
         match       <= 1'b0;
         match_count <= '0;
      end else begin
         word_valid <= 1'b0;
         match      <= 1'b0;
         if (sample_en) begin
            r_shift    <= w_word_next[WIDTH-2:0];
            r_window   <= w_window_next[PAT_LEN-2:0];
            r_fill_cnt <= w_fill_next;
            if (r_bit_cnt == BW'(WIDTH-1)) begin
               r_bit_cnt  <= '0;
               word_q     <= w_word_next;
               ones_count <= w_ones;
               word_valid <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            if (w_match_hit) begin
               match <= 1'b1;
               if (match_count != 8'hFF) begin
                  match_count <= match_count + 8'd1;
               end
            end
         end
      end
   end

`ifdef T_STREAM_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or posedge s_reset) begin
      if (s_reset) begin
         r_parity <= 1'b0;
      end else if (w_accept && (r_bit_cnt == BW'(WIDTH-1))) begin
         r_parity <= ^w_word_next;
      end
   end

   assign word_parity = r_parity;
`else
   assign word_parity = 1'b0;
`endif

endmodule

// File: tb/tb_t_stream_monitor.sv
// Scoreboard bench for t_stream_monitor: a bit-history reference model predicts every cycle's outputs.
module tb_t_stream_monitor;

   localparam int         W   = 8;
   localparam int         PL  = 4;
   localparam logic [3:0] PAT = 4'b1011;
   localparam int         CW  = $clog2(W+1);

   logic          clk;
   logic          s_reset;
   logic          T;
   logic          sample_en;
   logic          clear;
   logic [W-1:0]  word_q;
   logic          word_valid;
   logic [CW-1:0] ones_count;
   logic          match;
   logic [7:0]    match_count;
   logic [1:0]    state;
   logic          word_parity;

   t_stream_monitor #(.WIDTH(W), .PAT_LEN(PL), .PATTERN(PAT)) dut (
      .clk         (clk),
      .s_reset     (s_reset),
      .T           (T),
      .sample_en   (sample_en),
      .clear       (clear),
      .word_q      (word_q),
      .word_valid  (word_valid),
      .ones_count  (ones_count),
      .match       (match),
      .match_count (match_count),
      .state       (state),
      .word_parity (word_parity)
   );

   // Expected outputs one cycle after each driven edge.
   typedef struct {
      logic [1:0]    st;
      logic [W-1:0]  wq;
      logic [CW-1:0] oc;
      logic          wv;
      logic          m;
      logic [7:0]    mc;
      logic          par;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: everything derives from the list of bits accepted since the last clear/reset.
   bit            hist[$];
   logic [W-1:0]  m_word;
   logic [CW-1:0] m_ones;
   logic          m_par;
   logic          m_wv;
   logic          m_match;
   int            m_mc;

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   function automatic void model_reset();
      hist.delete();
      m_word  = '0;
      m_ones  = '0;
      m_par   = 1'b0;
      m_wv    = 1'b0;
      m_match = 1'b0;
      m_mc    = 0;
   endfunction

   function automatic logic [1:0] model_state();
      if (hist.size() == 0) return 2'd0;
      if (hist.size() < PL) return 2'd1;
      return 2'd2;
   endfunction

   task automatic model_step(input logic en, input logic clr, input logic t);
      logic [PL-1:0] win;
      m_wv    = 1'b0;
      m_match = 1'b0;
      if (clr) begin
         hist.delete();
         m_mc = 0;
      end else if (en) begin
         hist.push_back(t);
         if (hist.size() % W == 0) begin
            m_wv   = 1'b1;
            m_word = '0;
            for (int i = hist.size() - W; i < hist.size(); i++) m_word = {m_word[W-2:0], hist[i]};
            m_ones = CW'($countones(m_word));
`ifdef T_STREAM_PARITY_EN
            m_par  = ^m_word;
`endif
         end
         if (hist.size() >= PL) begin
            win = '0;
            for (int i = hist.size() - PL; i < hist.size(); i++) win = {win[PL-2:0], hist[i]};
            m_match = (win == PAT);
            if (m_match && m_mc < 255) m_mc++;
         end
      end
   endtask

   // driver tasks
   task automatic drive(input logic en, input logic clr, input logic t);
      exp_t e;
      @(negedge clk);
      sample_en = en;
      clear     = clr;
      T         = t;
      model_step(en, clr, t);
      e.st  = model_state();
      e.wq  = m_word;
      e.oc  = m_ones;
      e.wv  = m_wv;
      e.m   = m_match;
      e.mc  = 8'(m_mc);
      e.par = m_par;
      exp_q.push_back(e);
   endtask

   task automatic feed(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b0, bits[i]);
   endtask

   task automatic check_zero(input string nm);
      check({nm, "_state"}, state, 0);
      check({nm, "_word_q"}, word_q, 0);
      check({nm, "_ones"}, ones_count, 0);
      check({nm, "_word_valid"}, word_valid, 0);
      check({nm, "_match"}, match, 0);
      check({nm, "_match_count"}, match_count, 0);
      check({nm, "_parity"}, word_parity, 0);
   endtask

   // scoreboard monitor
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check("state", state, mon_e.st);
         check("word_q", word_q, mon_e.wq);
         check("ones_count", ones_count, mon_e.oc);
         check("word_valid", word_valid, mon_e.wv);
         check("match", match, mon_e.m);
         check("match_count", match_count, mon_e.mc);
         check("word_parity", word_parity, mon_e.par);
      end
   end

   initial begin
      s_reset   = 1'b1;
      T         = 1'b0;
      sample_en = 1'b0;
      clear     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("por");
      s_reset = 1'b0;

      // async reset mid-word, then a full word must take 8 fresh bits
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      sample_en = 1'b0;
      s_reset   = 1'b1;
      #1;
      check_zero("async_rst");
      model_reset();
      @(negedge clk);
      s_reset = 1'b0;
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));

      // single pattern
      drive(1'b0, 1'b1, 1'b0);
      feed(32'b1011, 4);

      // overlapping occurrences
      drive(1'b0, 1'b1, 1'b0);
      feed(32'b1011011, 7);

      // word assembled across sample_en gaps: expect 8'hCA
      drive(1'b0, 1'b1, 1'b0);
      begin
         logic [7:0] wbits;
         wbits = 8'hCA;
         for (int i = 7; i >= 0; i--) begin
            drive(1'b1, 1'b0, wbits[i]);
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end
      end

      // clear beats sample_en in ARMED with match_count=3
      feed(32'b1011011011, 10);
      drive(1'b1, 1'b1, 1'b1);
      feed(32'b1011, 4);

      // saturation: 260 overlapping matches
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 260; i++) feed(32'b011, 3);

      // random traffic with occasional clears
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
